// File: rtl/redux_v_pkg.sv
// -----------------------------------------------------------------------------
// redux_v_pkg
// Shared definitions for the REDUX-V multi-cycle core: opcode values,
// instruction field widths and the sequencing FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package redux_v_pkg;

   // Instruction field widths: op = instr[7:4], ra = instr[3:2], rb = instr[1:0],
   // imm4 = instr[3:0].
   localparam int INSTR_BITS   = 8;
   localparam int OP_BITS      = 4;
   localparam int REG_SEL_BITS = 2;
   localparam int IMM_BITS     = 4;
   localparam int NUM_REGS     = 4;

   localparam logic [OP_BITS-1:0] OP_BRZR = 4'd0;
   localparam logic [OP_BITS-1:0] OP_JI   = 4'd1;
   localparam logic [OP_BITS-1:0] OP_LD   = 4'd2;
   localparam logic [OP_BITS-1:0] OP_ST   = 4'd3;
   localparam logic [OP_BITS-1:0] OP_ADDI = 4'd4;
   localparam logic [OP_BITS-1:0] OP_NOT  = 4'd5;
   localparam logic [OP_BITS-1:0] OP_AND  = 4'd6;
   localparam logic [OP_BITS-1:0] OP_OR   = 4'd7;
   localparam logic [OP_BITS-1:0] OP_XOR  = 4'd8;
   localparam logic [OP_BITS-1:0] OP_ADD  = 4'd9;
   localparam logic [OP_BITS-1:0] OP_SUB  = 4'd10;
   localparam logic [OP_BITS-1:0] OP_MOV  = 4'd11;
   localparam logic [OP_BITS-1:0] OP_PUSH = 4'd12;
   localparam logic [OP_BITS-1:0] OP_POP  = 4'd13;
   localparam logic [OP_BITS-1:0] OP_HALT = 4'd14;
   localparam logic [OP_BITS-1:0] OP_ILL  = 4'd15;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/redux_v_regfile.sv
// -----------------------------------------------------------------------------
// redux_v_regfile
// Four BITS-wide general registers. Two combinational read ports, one
// synchronous write port, asynchronous active-low clear to zero.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   rd_a_sel, rd_a      read port A select / data
//   rd_b_sel, rd_b      read port B select / data
//   we, wr_sel, wr_data write enable / select / data (rising edge)
// -----------------------------------------------------------------------------
module redux_v_regfile
   import redux_v_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [REG_SEL_BITS-1:0] rd_a_sel,
   output logic [BITS-1:0]         rd_a,
   input  logic [REG_SEL_BITS-1:0] rd_b_sel,
   output logic [BITS-1:0]         rd_b,
   input  logic                    we,
   input  logic [REG_SEL_BITS-1:0] wr_sel,
   input  logic [BITS-1:0]         wr_data
);

   logic [BITS-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wr_sel] <= wr_data;
      end
   end

   assign rd_a = regs[rd_a_sel];
   assign rd_b = regs[rd_b_sel];

endmodule

// File: rtl/redux_v_mc.sv
// -----------------------------------------------------------------------------
// redux_v_mc
// Multi-cycle REDUX-V core. An FSM sequences FETCH -> EXEC -> (MEM) -> FETCH
// against external instruction and data memories with req/ack handshakes.
// Optional build macro: REDUX_V_ILLEGAL_TRAP_EN (opcode 15 traps into HALT and
// raises illegal_op; without it opcode 15 is a NOP and illegal_op is absent).
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   imem_req, imem_addr              fetch request / address (= pc)
//   imem_ack, imem_data              fetch complete / instruction byte
//   dmem_req, dmem_we, dmem_addr,
//   dmem_wdata                       data request / write / address / data
//   dmem_ack, dmem_rdata             access complete / read data
//   halted, dbg_pc                   core stopped / current pc
//   illegal_op                       opcode 15 trapped (macro builds only)
// Handshake: req, addr, we and wdata are registers that hold steady from the
// cycle req rises until the rising edge on which ack is seen high (which may be
// the first req cycle). req drops the cycle after that edge; ack with req low
// is ignored.
// ADDR_BITS must be at least 4 (sign-extended imm4 is added to pc).
// -----------------------------------------------------------------------------
module redux_v_mc
   import redux_v_pkg::*;
#(
   parameter int BITS      = 8,
   parameter int ADDR_BITS = 8,
   parameter int RESET_PC  = 0,
   parameter int SP_INIT   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req,
   output logic [ADDR_BITS-1:0] imem_addr,
   input  logic                 imem_ack,
   input  logic [7:0]           imem_data,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [ADDR_BITS-1:0] dmem_addr,
   output logic [BITS-1:0]      dmem_wdata,
   input  logic                 dmem_ack,
   input  logic [BITS-1:0]      dmem_rdata,
   output logic                 halted,
   output logic [ADDR_BITS-1:0] dbg_pc
`ifdef REDUX_V_ILLEGAL_TRAP_EN
   ,
   output logic                 illegal_op
`endif
);

   localparam logic [ADDR_BITS-1:0] A_ONE = ADDR_BITS'(1);

   state_t                  state, state_next;
   logic [ADDR_BITS-1:0]    pc, pc_next, pc_inc;
   logic [ADDR_BITS-1:0]    sp, sp_next;
   logic [INSTR_BITS-1:0]   ir;

   logic [OP_BITS-1:0]      op;
   logic [REG_SEL_BITS-1:0] ra_sel, rb_sel, a_sel, wr_sel;
   logic [IMM_BITS-1:0]     imm4;
   logic [BITS-1:0]         imm_data;
   logic [ADDR_BITS-1:0]    imm_addr;

   logic [BITS-1:0]         ra_data, rb_data, alu_res;
   logic [ADDR_BITS-1:0]    rb_addr;

   logic                    rf_we;
   logic [REG_SEL_BITS-1:0] rf_wsel;
   logic [BITS-1:0]         rf_wdata;

   logic                    fetch_done, mem_done;
   logic                    mem_start, mem_we_n;
   logic [ADDR_BITS-1:0]    mem_addr_n;
   logic [BITS-1:0]         mem_wdata_n;
   logic                    trap_set;

   assign op     = ir[INSTR_BITS-1 -: OP_BITS];
   assign ra_sel = ir[3:2];
   assign rb_sel = ir[1:0];
   assign imm4   = ir[IMM_BITS-1:0];

   assign imm_data = {{(BITS-IMM_BITS){imm4[IMM_BITS-1]}}, imm4};
   assign imm_addr = {{(ADDR_BITS-IMM_BITS){imm4[IMM_BITS-1]}}, imm4};
   assign pc_inc   = pc + A_ONE;

   // ADDI always works on R0, so port A and the write select are steered there.
   assign a_sel  = (op == OP_ADDI) ? '0 : ra_sel;
   assign wr_sel = (op == OP_ADDI) ? '0 : ra_sel;

   // Register values used as addresses: truncate (or zero-extend) to ADDR_BITS.
   assign rb_addr = ADDR_BITS'(rb_data);

   // Only a req that is actually up can be completed by an ack.
   assign fetch_done = imem_req & imem_ack;
   assign mem_done   = dmem_req & dmem_ack;

   redux_v_regfile #(.BITS(BITS)) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_a_sel (a_sel),
      .rd_a     (ra_data),
      .rd_b_sel (rb_sel),
      .rd_b     (rb_data),
      .we       (rf_we),
      .wr_sel   (rf_wsel),
      .wr_data  (rf_wdata)
   );

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADDI: alu_res = ra_data + imm_data;
         OP_NOT:  alu_res = ~rb_data;
         OP_AND:  alu_res = ra_data & rb_data;
         OP_OR:   alu_res = ra_data | rb_data;
         OP_XOR:  alu_res = ra_data ^ rb_data;
         OP_ADD:  alu_res = ra_data + rb_data;
         OP_SUB:  alu_res = ra_data - rb_data;
         OP_MOV:  alu_res = rb_data;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_next  = state;
      pc_next     = pc;
      sp_next     = sp;
      rf_we       = 1'b0;
      rf_wsel     = wr_sel;
      rf_wdata    = alu_res;
      mem_start   = 1'b0;
      mem_we_n    = 1'b0;
      mem_addr_n  = '0;
      mem_wdata_n = '0;
      trap_set    = 1'b0;
      case (state)
         S_FETCH: begin
            if (fetch_done) state_next = S_EXEC;
         end
         S_EXEC: begin
            state_next = S_FETCH;
            case (op)
               OP_BRZR: pc_next = (ra_data == '0) ? rb_addr : pc_inc;
               OP_JI:   pc_next = pc + imm_addr;
               OP_LD: begin
                  mem_start  = 1'b1;
                  mem_addr_n = rb_addr;
                  state_next = S_MEM;
               end
               OP_ST: begin
                  mem_start   = 1'b1;
                  mem_we_n    = 1'b1;
                  mem_addr_n  = rb_addr;
                  mem_wdata_n = ra_data;
                  state_next  = S_MEM;
               end
               OP_PUSH: begin
                  // Pre-decrement; SP itself is committed on the ack edge.
                  mem_start   = 1'b1;
                  mem_we_n    = 1'b1;
                  mem_addr_n  = sp - A_ONE;
                  mem_wdata_n = ra_data;
                  state_next  = S_MEM;
               end
               OP_POP: begin
                  mem_start  = 1'b1;
                  mem_addr_n = sp;
                  state_next = S_MEM;
               end
               OP_HALT: state_next = S_HALT;
               OP_ILL: begin
`ifdef REDUX_V_ILLEGAL_TRAP_EN
                  trap_set   = 1'b1;
                  state_next = S_HALT;
`else
                  pc_next    = pc_inc;
`endif
               end
               OP_ADDI, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MOV: begin
                  rf_we   = 1'b1;
                  pc_next = pc_inc;
               end
               default: pc_next = pc_inc;
            endcase
         end
         S_MEM: begin
            if (mem_done) begin
               state_next = S_FETCH;
               pc_next    = pc_inc;
               if (op == OP_LD || op == OP_POP) begin
                  rf_we    = 1'b1;
                  rf_wsel  = ra_sel;
                  rf_wdata = dmem_rdata;
               end
               if (op == OP_PUSH) sp_next = sp - A_ONE;
               if (op == OP_POP)  sp_next = sp + A_ONE;
            end
         end
         S_HALT: state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         pc         <= ADDR_BITS'(RESET_PC);
         sp         <= ADDR_BITS'(SP_INIT);
         ir         <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         sp       <= sp_next;
         if (state == S_FETCH && fetch_done) ir <= imem_data;
         // The fetch request is up for exactly the cycles spent in FETCH
         // (after the first post-reset edge).
         imem_req <= (state_next == S_FETCH);
         if (mem_start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_we_n;
            dmem_addr  <= mem_addr_n;
            dmem_wdata <= mem_wdata_n;
         end else if (mem_done) begin
            dmem_req <= 1'b0;
         end
      end
   end

`ifdef REDUX_V_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        illegal_op <= 1'b0;
      else if (trap_set) illegal_op <= 1'b1;
   end
`else
   logic unused_trap;
   assign unused_trap = trap_set;
`endif

   assign imem_addr = pc;
   assign dbg_pc    = pc;
   assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_redux_v_mc.sv
// -----------------------------------------------------------------------------
// tb_redux_v_mc
// Directed programs for redux_v_mc (BITS=16, ADDR_BITS=8) with wait-state
// memory models. Expected data-memory writes are queued per program and a
// monitor pops and compares them as the core performs each write, also
// checking that the data request stays stable until ack.
// -----------------------------------------------------------------------------
module tb_redux_v_mc;

   localparam int BITS      = 16;
   localparam int ADDR_BITS = 8;

   logic                 clk;
   logic                 rst_n;
   logic                 imem_req;
   logic [ADDR_BITS-1:0] imem_addr;
   logic                 imem_ack;
   logic [7:0]           imem_data;
   logic                 dmem_req;
   logic                 dmem_we;
   logic [ADDR_BITS-1:0] dmem_addr;
   logic [BITS-1:0]      dmem_wdata;
   logic                 dmem_ack;
   logic [BITS-1:0]      dmem_rdata;
   logic                 halted;
   logic [ADDR_BITS-1:0] dbg_pc;
`ifdef REDUX_V_ILLEGAL_TRAP_EN
   logic                 illegal_op;
`endif

   redux_v_mc #(
      .BITS(BITS), .ADDR_BITS(ADDR_BITS), .RESET_PC(0), .SP_INIT(0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_data  (imem_data),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .halted     (halted),
      .dbg_pc     (dbg_pc)
`ifdef REDUX_V_ILLEGAL_TRAP_EN
      ,
      .illegal_op (illegal_op)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory models ----------------
   logic [7:0]      imem [256];
   logic [BITS-1:0] dmem [256];
   int i_wait = 0;
   int d_wait = 0;
   int i_cnt  = 0;
   int d_cnt  = 0;

   assign imem_ack   = imem_req && (i_cnt >= i_wait);
   assign imem_data  = imem[imem_addr];
   assign dmem_ack   = dmem_req && (d_cnt >= d_wait);
   assign dmem_rdata = dmem[dmem_addr];

   always @(posedge clk) begin
      if (imem_req && !imem_ack) i_cnt <= i_cnt + 1;
      else                       i_cnt <= 0;
      if (dmem_req && !dmem_ack) d_cnt <= d_cnt + 1;
      else                       d_cnt <= 0;
      if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
   end

   // ---------------- scoreboard ----------------
   logic [23:0] exp_q [$];
   logic [7:0]  prog_q [$];
   int n_cmp  = 0;
   int n_fail = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endfunction

   // Monitor: compares each completed write against the queue head and
   // checks request stability while waiting for ack.
   logic                 pend = 1'b0;
   int                   req_len = 0;
   logic                 p_we;
   logic [ADDR_BITS-1:0] p_addr;
   logic [BITS-1:0]      p_wdata;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend    = 1'b0;
         req_len = 0;
      end else begin
         if (pend) begin
            check("dmem_req_held", {31'b0, dmem_req}, 32'd1);
            if (dmem_req) begin
               check("dmem_addr_stable", {24'b0, dmem_addr}, {24'b0, p_addr});
               check("dmem_wdata_stable", {16'b0, dmem_wdata}, {16'b0, p_wdata});
               check("dmem_we_stable", {31'b0, dmem_we}, {31'b0, p_we});
            end
         end
         if (dmem_req) req_len++;
         if (dmem_req && dmem_ack) begin
            if (dmem_we) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_write: actual %0h@%0h required none",
                           dmem_wdata, dmem_addr);
               end else begin
                  check("dmem_write", {8'b0, dmem_addr, dmem_wdata},
                        {8'b0, exp_q.pop_front()});
               end
               check("write_req_cycles", req_len, d_wait + 1);
            end
            pend    = 1'b0;
            req_len = 0;
         end else if (dmem_req) begin
            pend    = 1'b1;
            p_we    = dmem_we;
            p_addr  = dmem_addr;
            p_wdata = dmem_wdata;
         end else begin
            pend    = 1'b0;
            req_len = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_prog(input int base);
      for (int a = 0; a < 256; a++) imem[a] = 8'h30;  // stray path: ST R0,[R0]
      for (int k = 0; k < prog_q.size(); k++) imem[(base + k) % 256] = prog_q[k];
   endtask

   task automatic load_more(input int base);
      for (int k = 0; k < prog_q.size(); k++) imem[(base + k) % 256] = prog_q[k];
   endtask

   task automatic run_to_halt(input string name, input logic [7:0] exp_pc);
      int cyc;
      cyc = 0;
      @(negedge clk);
      rst_n = 1'b1;
      while (!halted && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_halted"}, {31'b0, halted}, 32'd1);
      check({name, "_dbg_pc"}, {24'b0, dbg_pc}, {24'b0, exp_pc});
      repeat (2) @(negedge clk);
      check({name, "_writes_left"}, exp_q.size(), 32'd0);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
      check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
      check("rst_dmem_addr", {24'b0, dmem_addr}, 32'd0);
      check("rst_dmem_wdata", {16'b0, dmem_wdata}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_dbg_pc", {24'b0, dbg_pc}, 32'd0);
`ifdef REDUX_V_ILLEGAL_TRAP_EN
      check("rst_illegal_op", {31'b0, illegal_op}, 32'd0);
`endif

      // 1: ADDI +5; ADDI -1; MOV R1,R0; HALT -- 4 x 2 cycles from first fetch
      prog_q = '{8'h45, 8'h4F, 8'hB4, 8'hE0};
      load_prog(0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      while (!imem_req && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check("t1_fetch_start", {31'b0, imem_req}, 32'd1);
      cyc = 0;
      while (!halted && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("t1_halt_cycles", cyc, 32'd8);
      check("t1_dbg_pc", {24'b0, dbg_pc}, 32'd3);
      check("t1_halt_no_fetch", {31'b0, imem_req}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);

      // 1b: same, then expose R0/R1 through stores
      prog_q = '{8'h45, 8'h4F, 8'hB4, 8'h31, 8'h41, 8'h34, 8'hE0};
      load_prog(0);
      exp_q.push_back({8'h04, 16'h0004});
      exp_q.push_back({8'h05, 16'h0004});
      run_to_halt("t1b", 8'h06);

      // 2: build R1=0x10, R0=0xABCD, ST R0,[R1], LD R2,[R1], ST R2,[R0]
      i_wait = 1;
      d_wait = 3;
      prog_q = '{8'h47, 8'h47, 8'h42, 8'hB4, 8'h80,
                 8'h47, 8'h43, 8'h90, 8'h90, 8'h90, 8'h90,
                 8'h47, 8'h44, 8'h90, 8'h90, 8'h90, 8'h90,
                 8'h47, 8'h45, 8'h90, 8'h90, 8'h90, 8'h90,
                 8'h47, 8'h46, 8'h31, 8'h29, 8'h38, 8'hE0};
      load_prog(0);
      exp_q.push_back({8'h10, 16'hABCD});
      exp_q.push_back({8'hCD, 16'hABCD});
      run_to_halt("t2", 8'h1C);

      // 3: BRZR taken to 0x20, BRZR not taken, JI +3 then JI -2 (0xE)
      i_wait = 2;
      d_wait = 0;
      prog_q = '{8'h47, 8'h47, 8'h47, 8'h47, 8'h44, 8'hB4, 8'h80, 8'h01};
      load_prog(0);
      prog_q = '{8'h41, 8'h01, 8'h41, 8'h13, 8'h31, 8'hE0, 8'h1E};
      load_more(8'h20);
      exp_q.push_back({8'h20, 16'h0002});
      run_to_halt("t3", 8'h25);

      // 4: PUSH at SP=0 wraps to 0xFF, POP at 0xFF wraps back to 0
      i_wait = 0;
      d_wait = 1;
      prog_q = '{8'h47, 8'hC0, 8'hDC, 8'h41, 8'h3C, 8'hC0, 8'hE0};
      load_prog(0);
      exp_q.push_back({8'hFF, 16'h0007});
      exp_q.push_back({8'h08, 16'h0007});
      exp_q.push_back({8'hFF, 16'h0008});
      run_to_halt("t4", 8'h06);

      // 5: reset while a load waits for an ack that never comes
      d_wait = 100000;
      prog_q = '{8'h45, 8'h28};
      load_prog(0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      while (!dmem_req && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_mem_pending", {31'b0, dmem_req}, 32'd1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_dmem_req", {31'b0, dmem_req}, 32'd0);
      check("t5_async_dmem_addr", {24'b0, dmem_addr}, 32'd0);
      check("t5_async_pc", {24'b0, dbg_pc}, 32'd0);
      @(negedge clk);
      d_wait = 0;
      prog_q = '{8'h45, 8'h38, 8'hE0};
      load_prog(0);
      exp_q.push_back({8'h05, 16'h0000});
      run_to_halt("t5", 8'h02);

      // 6: opcode 0xF0
      prog_q = '{8'h41, 8'hF0, 8'h30, 8'hE0};
      load_prog(0);
`ifdef REDUX_V_ILLEGAL_TRAP_EN
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      while (!halted && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("t6_halted", {31'b0, halted}, 32'd1);
      check("t6_illegal_op", {31'b0, illegal_op}, 32'd1);
      check("t6_dbg_pc", {24'b0, dbg_pc}, 32'd1);
      check("t6_no_writes", exp_q.size(), 32'd0);
      rst_n = 1'b0;
      #1;
      check("t6_illegal_cleared", {31'b0, illegal_op}, 32'd0);
      @(negedge clk);
`else
      exp_q.push_back({8'h01, 16'h0001});
      run_to_halt("t6", 8'h03);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
